// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//   Game score / lives tracker with a three-state game FSM (IDLE, PLAY, OVER).
//   start, hit and miss are level inputs; each goes through a one-flop rising
//   edge detector, so a held level counts as a single event. The score is
//   kept twice: as a binary count and as a BCD counter updated in lock-step,
//   so the 7-segment stage gets its digits without a divider.
//
//   Optional feature (macro SCORE_KEEPER_HIGH_SCORE_EN):
//     defined   -> best holds max(best, final score), captured on PLAY->OVER;
//                  only reset clears it.
//     undefined -> best is tied to 0 and no best register exists.
//
// Parameters
//   MAX_SCORE    score saturation ceiling (1..99)
//   START_LIVES  lives loaded when a game starts (1..3)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   level; rising edge starts a new game (from IDLE or OVER)
//   hit        in   level; rising edge scores one point while playing
//   miss       in   level; rising edge loses one life while playing
//   score      out  [6:0] binary score, 0..MAX_SCORE
//   score_bcd  out  [7:0] {tens, units} BCD digits of score
//   lives      out  [1:0] remaining lives
//   playing    out  high in PLAY
//   game_over  out  high in OVER
//   best       out  [6:0] best final score (0 when the feature is disabled)
// ---------------------------------------------------------------------------
module score_keeper #(
    parameter int MAX_SCORE   = 99,
    parameter int START_LIVES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [6:0] score,
    output logic [7:0] score_bcd,
    output logic [1:0] lives,
    output logic       playing,
    output logic       game_over,
    output logic [6:0] best
);

    localparam logic [6:0] MAX_S   = 7'(MAX_SCORE);
    localparam logic [1:0] START_L = 2'(START_LIVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] score_nxt;
    logic [7:0] bcd_nxt;
    logic [1:0] lives_nxt;

    // Edge-detector history. Cleared by reset, so an input held high across
    // reset release is seen as a fresh rising edge on the first edge after.
    logic start_prev, hit_prev, miss_prev;
    logic start_ev, hit_ev, miss_ev;

    assign start_ev = start & ~start_prev;
    assign hit_ev   = hit   & ~hit_prev;
    assign miss_ev  = miss  & ~miss_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev <= 1'b0;
            hit_prev   <= 1'b0;
            miss_prev  <= 1'b0;
        end else begin
            start_prev <= start;
            hit_prev   <= hit;
            miss_prev  <= miss;
        end
    end

    // Next-state and datapath. Hit and miss are evaluated independently so a
    // simultaneous pair applies both, even when the miss ends the game.
    always_comb begin
        state_nxt = state;
        score_nxt = score;
        bcd_nxt   = score_bcd;
        lives_nxt = lives;
        case (state)
            IDLE, OVER: begin
                if (start_ev) begin
                    state_nxt = PLAY;
                    score_nxt = 7'd0;
                    bcd_nxt   = 8'h00;
                    lives_nxt = START_L;
                end
            end
            PLAY: begin
                if (hit_ev && (score != MAX_S)) begin
                    score_nxt = score + 7'd1;
                    // BCD increment: units wrap 9->0 and carry into tens.
                    if (score_bcd[3:0] == 4'd9) begin
                        bcd_nxt[3:0] = 4'd0;
                        bcd_nxt[7:4] = score_bcd[7:4] + 4'd1;
                    end else begin
                        bcd_nxt[3:0] = score_bcd[3:0] + 4'd1;
                    end
                end
                if (miss_ev) begin
                    lives_nxt = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_nxt = OVER;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            score     <= 7'd0;
            score_bcd <= 8'h00;
            lives     <= 2'd0;
        end else begin
            state     <= state_nxt;
            score     <= score_nxt;
            score_bcd <= bcd_nxt;
            lives     <= lives_nxt;
        end
    end

    assign playing   = (state == PLAY);
    assign game_over = (state == OVER);

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    // Capture uses score_nxt so a hit landing with the final miss counts.
    logic [6:0] best_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            best_q <= 7'd0;
        end else if ((state == PLAY) && (state_nxt == OVER) && (score_nxt > best_q)) begin
            best_q <= score_nxt;
        end
    end

    assign best = best_q;
`else
    assign best = 7'd0;
`endif

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_SCORE, default 99: score saturation ceiling, legal range 1..99.
REQ-002 Parameter START_LIVES, default 3: lives loaded on game start, legal range 1..3.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; rising edge requests a new game.
REQ-006 hit  input  1  level; rising edge means one point scored.
REQ-007 miss  input  1  level; rising edge means one life lost.
REQ-008 score  output  7  binary score, 0..MAX_SCORE.
REQ-009 score_bcd  output  8  [7:4] tens digit, [3:0] units digit of score; feeds the 7-segment stage.
REQ-010 lives  output  2  remaining lives.
REQ-011 playing  output  1  high in state PLAY.
REQ-012 game_over  output  1  high in state OVER.
REQ-013 best  output  7  best score; see Configuration.

Function
REQ-014 Each of start, hit and miss SHALL pass through a 1-flop edge detector; an event is a sample of 1 where the previous sample was 0; a held level yields exactly one event.
REQ-015 The FSM SHALL have three states: IDLE, PLAY and OVER.
REQ-016 IDLE --start event--> PLAY, and OVER --start event--> PLAY; on that transition score=0, score_bcd=0x00 and lives=START_LIVES.
REQ-017 In PLAY a hit event SHALL increment score by 1, saturating at MAX_SCORE; when saturated, further hits have no effect.
REQ-018 In PLAY a miss event SHALL decrement lives by 1; the miss that takes lives to 0 moves the FSM to OVER.
REQ-019 A hit event and a miss event in the same cycle SHALL both be applied (score+1, lives-1), including when the miss ends the game.
REQ-020 A start event in PLAY SHALL be ignored; hit and miss events in IDLE or OVER SHALL be ignored.
REQ-021 score SHALL hold its value in OVER until the next start event.
REQ-022 Latency: an event detected at rising edge k SHALL update all outputs at edge k+1; all outputs are registered.
REQ-023 score_bcd SHALL be maintained as a registered BCD counter in parallel with score, so that score_bcd always equals the decimal digits of score; units wrap 9->0 with tens+1, and no divider is used.
REQ-024 playing and game_over SHALL be decoded from the registered state; they are never both high.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, score=0, score_bcd=0x00, lives=0, playing=0, game_over=0, best=0, and the edge-detector history flops are cleared.
REQ-026 Reset asserted mid-game SHALL abort the game with no score capture into best.
REQ-027 An input held high across reset release SHALL produce an event on the first edge after release.

Configuration
REQ-028 Macro SCORE_KEEPER_HIGH_SCORE_EN: when defined, on the PLAY->OVER transition best SHALL become max(best, final score) at the same edge; best survives start events and is cleared only by reset.
REQ-029 When SCORE_KEEPER_HIGH_SCORE_EN is not defined, best SHALL be tied to 0 and no best register is instantiated.

Verification
REQ-030 Reset, then pulse start, then 12 hit pulses -> score=12, score_bcd=0x12, lives=3, playing=1.
REQ-031 Hold hit high for 10 cycles in PLAY -> score increments by exactly 1.
REQ-032 MAX_SCORE=99 with 105 hits -> score=99, score_bcd=0x99, with no wrap.
REQ-033 Score 5, lives=1, hit and miss rising in the same cycle -> next cycle score=6, lives=0, game_over=1; with the macro defined, best=6.
REQ-034 Play to 7 and lose, then start, play to 3 and lose -> score=3 and best=7 with the macro defined; best=0 without it.
REQ-035 Assert reset at score 40 in PLAY -> next cycle all outputs are 0 and state is IDLE; hit pulses are then ignored until a start event.
